// File: rtl/io_uart_in.sv
// Receive-side UART buffer on the IO bus: bytes from the UART receiver are queued
// in a small FIFO and popped by DATA reads; STAT/CTRL expose and configure the buffer.
module io_uart_in #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [13:0] ADR_DATA   = 14'h0080,
    parameter logic [13:0] ADR_STAT   = 14'h0081,
    parameter logic [13:0] ADR_CTRL   = 14'h0082
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  uart_rx_char,
    input  logic        uart_rx_we,
    input  logic        dma_io_we,
    input  logic [13:0] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [13:0] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    output logic        uart_rx_irq
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        RSEL_NONE,
        RSEL_DATA,
        RSEL_STAT,
        RSEL_CTRL
    } rsel_e;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  irq_en_q, irq_en_d;
    logic                  hit_q, hit_d;
    logic [31:0]           rdata_q, rdata_d;

    rsel_e       rsel;
    logic        empty;
    logic        full;
    logic        pop;
    logic        ctrl_wr;
    logic        flush;
    logic        push_req;
    logic        push;
    logic        drop;
    logic [31:0] stat_word;
    logic        unused_wdata;

    assign unused_wdata = ^dma_io_wdata[31:3];

    always_comb begin
        rsel = RSEL_NONE;
        if (!rst && dma_io_radr_en) begin
            if (dma_io_radr == ADR_DATA) begin
                rsel = RSEL_DATA;
            end else if (dma_io_radr == ADR_STAT) begin
                rsel = RSEL_STAT;
            end else if (dma_io_radr == ADR_CTRL) begin
                rsel = RSEL_CTRL;
            end
        end
    end

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_COUNT);
    assign pop      = (rsel == RSEL_DATA) && !empty;
    assign ctrl_wr  = !rst && dma_io_we && (dma_io_wadr == ADR_CTRL);
    assign flush    = ctrl_wr && dma_io_wdata[2];
    // A flush swallows any same-cycle byte, so it never counts as an overrun.
    assign push_req = !rst && uart_rx_we && !flush;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        stat_word                = '0;
        stat_word[DEPTH_LOG2:0]  = count_q;
        stat_word[8]             = empty;
        stat_word[9]             = full;
        stat_word[10]            = overrun_q;
        stat_word[16]            = irq_en_q;
    end

    always_comb begin
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        irq_en_d  = irq_en_q;
        hit_d     = 1'b0;
        rdata_d   = '0;

        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end

        if (ctrl_wr) begin
            irq_en_d = dma_io_wdata[0];
            if (dma_io_wdata[1]) begin
                overrun_d = 1'b0;
            end
        end
        // A byte lost in the same cycle as a clear still leaves the flag set.
        if (drop) begin
            overrun_d = 1'b1;
        end

        case (rsel)
            RSEL_DATA: begin
                hit_d = 1'b1;
                if (!empty) begin
                    rdata_d = {23'd0, 1'b1, mem_q[rptr_q]};
                end
            end
            RSEL_STAT: begin
                hit_d   = 1'b1;
                rdata_d = stat_word;
            end
            RSEL_CTRL: begin
                hit_d   = 1'b1;
                rdata_d = {31'd0, irq_en_q};
            end
            default: begin
                hit_d   = 1'b0;
                rdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q    <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            irq_en_q  <= 1'b0;
            hit_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            irq_en_q  <= irq_en_d;
            hit_q     <= hit_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= uart_rx_char;
        end
    end

    assign dma_io_rdata = (hit_q && !rst) ? rdata_q : dma_io_rdata_in;
    assign uart_rx_irq  = !rst && irq_en_q && !empty;

endmodule

// File: tb/tb_io_uart_in.sv
// Self-checking bench for io_uart_in: directed scenarios plus randomized traffic
// compared against a queue-based model of the receive buffer.
module tb_io_uart_in;

    localparam int unsigned DEPTH = 16;
    localparam logic [13:0] ADR_DATA = 14'h0080;
    localparam logic [13:0] ADR_STAT = 14'h0081;
    localparam logic [13:0] ADR_CTRL = 14'h0082;
    localparam logic [31:0] RIN      = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  uart_rx_char;
    logic        uart_rx_we;
    logic        dma_io_we;
    logic [13:0] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic [13:0] dma_io_radr;
    logic        dma_io_radr_en;
    logic [31:0] dma_io_rdata_in;
    logic [31:0] dma_io_rdata;
    logic        uart_rx_irq;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mq[$];
    logic        m_ovr;
    logic        m_irq_en;
    logic [31:0] exp_rdata;
    logic        exp_irq;
    logic [31:0] obs_rdata;
    logic        obs_irq;

    io_uart_in #(
        .DEPTH_LOG2(4),
        .ADR_DATA  (ADR_DATA),
        .ADR_STAT  (ADR_STAT),
        .ADR_CTRL  (ADR_CTRL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .uart_rx_char   (uart_rx_char),
        .uart_rx_we     (uart_rx_we),
        .dma_io_we      (dma_io_we),
        .dma_io_wadr    (dma_io_wadr),
        .dma_io_wdata   (dma_io_wdata),
        .dma_io_radr    (dma_io_radr),
        .dma_io_radr_en (dma_io_radr_en),
        .dma_io_rdata_in(dma_io_rdata_in),
        .dma_io_rdata   (dma_io_rdata),
        .uart_rx_irq    (uart_rx_irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_stat();
        logic e;
        logic f;
        e = (mq.size() == 0);
        f = (mq.size() == DEPTH);
        return {15'd0, m_irq_en, 5'd0, m_ovr, f, e, 3'd0, 5'(mq.size())};
    endfunction

    // One bus cycle: the model predicts from pre-edge state, the DUT is sampled 1ns after the edge.
    task automatic cyc(input logic r, input logic we, input logic [7:0] ch,
                       input logic rd, input logic [13:0] ra,
                       input logic wr, input logic [13:0] wa, input logic [31:0] wd,
                       input logic [31:0] rin);
        logic flush;
        exp_rdata = rin;
        if (r) begin
            mq.delete();
            m_ovr    = 1'b0;
            m_irq_en = 1'b0;
            exp_irq  = 1'b0;
        end else begin
            if (rd) begin
                if (ra == ADR_DATA) begin
                    if (mq.size() > 0) begin
                        exp_rdata = {23'd0, 1'b1, mq[0]};
                        void'(mq.pop_front());
                    end else begin
                        exp_rdata = 32'd0;
                    end
                end else if (ra == ADR_STAT) begin
                    exp_rdata = m_stat();
                end else if (ra == ADR_CTRL) begin
                    exp_rdata = {31'd0, m_irq_en};
                end
            end
            flush = wr && (wa == ADR_CTRL) && wd[2];
            if (wr && (wa == ADR_CTRL)) begin
                m_irq_en = wd[0];
                if (wd[1]) m_ovr = 1'b0;
            end
            if (flush) begin
                mq.delete();
            end else if (we) begin
                if (mq.size() < DEPTH) mq.push_back(ch);
                else m_ovr = 1'b1;
            end
            exp_irq = m_irq_en && (mq.size() != 0);
        end

        rst             = r;
        uart_rx_we      = we;
        uart_rx_char    = ch;
        dma_io_radr_en  = rd;
        dma_io_radr     = ra;
        dma_io_we       = wr;
        dma_io_wadr     = wa;
        dma_io_wdata    = wd;
        dma_io_rdata_in = rin;
        @(posedge clk);
        #1;
        obs_rdata = dma_io_rdata;
        obs_irq   = uart_rx_irq;
        rst            = 1'b0;
        uart_rx_we     = 1'b0;
        dma_io_radr_en = 1'b0;
        dma_io_we      = 1'b0;
    endtask

    task automatic push(input logic [7:0] ch);
        cyc(1'b0, 1'b1, ch, 1'b0, 14'd0, 1'b0, 14'd0, 32'd0, RIN);
    endtask

    task automatic rd(input logic [13:0] adr);
        cyc(1'b0, 1'b0, 8'd0, 1'b1, adr, 1'b0, 14'd0, 32'd0, RIN);
    endtask

    task automatic wctrl(input logic [31:0] wd);
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 14'd0, 1'b1, ADR_CTRL, wd, RIN);
    endtask

    task automatic test_reset();
        logic [31:0] rin;
        for (int i = 0; i < 3; i++) begin
            rin = $urandom;
            cyc(1'b1, 1'b1, 8'h5A, 1'b1, ADR_DATA, 1'b1, ADR_CTRL, 32'h1, rin);
            checks++;
            if (obs_rdata !== rin) begin
                errors++;
                $display("FAIL reset_passthru: got %h expected %h", obs_rdata, rin);
            end
            checks++;
            if (obs_irq !== 1'b0) begin
                errors++;
                $display("FAIL reset_irq: got %b expected 0", obs_irq);
            end
        end
        rd(ADR_STAT);
        checks++;
        if (obs_rdata !== 32'h0000_0100) begin
            errors++;
            $display("FAIL reset_stat: got %h expected 00000100", obs_rdata);
        end
        // Mid-operation reset drops buffered bytes and irq_en.
        push(8'h01); push(8'h02); push(8'h03);
        wctrl(32'h1);
        checks++;
        if (obs_irq !== 1'b1) begin
            errors++;
            $display("FAIL midreset_irq_before: got %b expected 1", obs_irq);
        end
        cyc(1'b1, 1'b0, 8'd0, 1'b0, 14'd0, 1'b0, 14'd0, 32'd0, RIN);
        rd(ADR_STAT);
        checks++;
        if (obs_rdata !== 32'h0000_0100) begin
            errors++;
            $display("FAIL midreset_stat: got %h expected 00000100", obs_rdata);
        end
        rd(ADR_DATA);
        checks++;
        if (obs_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_data: got %h expected 00000000", obs_rdata);
        end
        rd(ADR_CTRL);
        checks++;
        if (obs_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_ctrl: got %h expected 00000000", obs_rdata);
        end
    endtask

    task automatic test_basic();
        push(8'h41);
        push(8'h42);
        rd(ADR_DATA);
        checks++;
        if (obs_rdata !== 32'h0000_0141) begin
            errors++;
            $display("FAIL basic_rd1: got %h expected 00000141", obs_rdata);
        end
        rd(ADR_DATA);
        checks++;
        if (obs_rdata !== 32'h0000_0142) begin
            errors++;
            $display("FAIL basic_rd2: got %h expected 00000142", obs_rdata);
        end
        rd(ADR_DATA);
        checks++;
        if (obs_rdata !== 32'h0) begin
            errors++;
            $display("FAIL basic_rd_empty: got %h expected 00000000", obs_rdata);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 17; i++) push(8'h10 + 8'(i));
        rd(ADR_STAT);
        checks++;
        if (obs_rdata !== 32'h0000_0610) begin
            errors++;
            $display("FAIL overrun_stat: got %h expected 00000610", obs_rdata);
        end
        for (int i = 0; i < 16; i++) begin
            rd(ADR_DATA);
            checks++;
            if (obs_rdata !== {23'd0, 1'b1, 8'h10 + 8'(i)}) begin
                errors++;
                $display("FAIL overrun_drain[%0d]: got %h expected %h", i, obs_rdata,
                         {23'd0, 1'b1, 8'h10 + 8'(i)});
            end
        end
        rd(ADR_DATA);
        checks++;
        if (obs_rdata !== 32'h0) begin
            errors++;
            $display("FAIL overrun_lost17: got %h expected 00000000", obs_rdata);
        end
        wctrl(32'h2);
        rd(ADR_STAT);
        checks++;
        if (obs_rdata !== 32'h0000_0100) begin
            errors++;
            $display("FAIL overrun_clear: got %h expected 00000100", obs_rdata);
        end
    endtask

    task automatic test_irq();
        wctrl(32'h1);
        checks++;
        if (obs_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_empty: got %b expected 0", obs_irq);
        end
        push(8'h55);
        checks++;
        if (obs_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_after_push: got %b expected 1", obs_irq);
        end
        rd(ADR_DATA);
        checks++;
        if (obs_rdata !== 32'h0000_0155) begin
            errors++;
            $display("FAIL irq_pop_data: got %h expected 00000155", obs_rdata);
        end
        checks++;
        if (obs_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_after_pop: got %b expected 0", obs_irq);
        end
        rd(ADR_CTRL);
        checks++;
        if (obs_rdata !== 32'h1) begin
            errors++;
            $display("FAIL irq_ctrl_read: got %h expected 00000001", obs_rdata);
        end
        wctrl(32'h0);
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        cyc(1'b0, 1'b1, 8'hEE, 1'b1, ADR_DATA, 1'b0, 14'd0, 32'd0, RIN);
        checks++;
        if (obs_rdata !== 32'h0000_0120) begin
            errors++;
            $display("FAIL full_pp_head: got %h expected 00000120", obs_rdata);
        end
        rd(ADR_STAT);
        checks++;
        if (obs_rdata !== 32'h0000_0210) begin
            errors++;
            $display("FAIL full_pp_stat: got %h expected 00000210", obs_rdata);
        end
        for (int i = 1; i < 16; i++) begin
            rd(ADR_DATA);
            checks++;
            if (obs_rdata !== {23'd0, 1'b1, 8'h20 + 8'(i)}) begin
                errors++;
                $display("FAIL full_pp_drain[%0d]: got %h expected %h", i, obs_rdata,
                         {23'd0, 1'b1, 8'h20 + 8'(i)});
            end
        end
        rd(ADR_DATA);
        checks++;
        if (obs_rdata !== 32'h0000_01EE) begin
            errors++;
            $display("FAIL full_pp_newbyte: got %h expected 000001ee", obs_rdata);
        end
    endtask

    task automatic test_empty_pushpop();
        cyc(1'b0, 1'b1, 8'h99, 1'b1, ADR_DATA, 1'b0, 14'd0, 32'd0, RIN);
        checks++;
        if (obs_rdata !== 32'h0) begin
            errors++;
            $display("FAIL empty_pp_read: got %h expected 00000000", obs_rdata);
        end
        rd(ADR_STAT);
        checks++;
        if (obs_rdata !== 32'h0000_0001) begin
            errors++;
            $display("FAIL empty_pp_stat: got %h expected 00000001", obs_rdata);
        end
        rd(ADR_DATA);
        checks++;
        if (obs_rdata !== 32'h0000_0199) begin
            errors++;
            $display("FAIL empty_pp_data: got %h expected 00000199", obs_rdata);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 17; i++) push(8'h30 + 8'(i));
        cyc(1'b0, 1'b1, 8'h77, 1'b0, 14'd0, 1'b1, ADR_CTRL, 32'h6, RIN);
        rd(ADR_STAT);
        checks++;
        if (obs_rdata !== 32'h0000_0100) begin
            errors++;
            $display("FAIL flush_stat: got %h expected 00000100", obs_rdata);
        end
        rd(ADR_DATA);
        checks++;
        if (obs_rdata !== 32'h0) begin
            errors++;
            $display("FAIL flush_data: got %h expected 00000000", obs_rdata);
        end
    endtask

    task automatic test_unmapped();
        push(8'h3C);
        cyc(1'b0, 1'b0, 8'd0, 1'b1, 14'h0123, 1'b0, 14'd0, 32'd0, 32'hDEAD_BEEF);
        checks++;
        if (obs_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL unmapped_read: got %h expected deadbeef", obs_rdata);
        end
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 14'd0, 1'b1, 14'h0083, 32'h7, 32'hCAFE_F00D);
        checks++;
        if (obs_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL idle_passthru: got %h expected cafef00d", obs_rdata);
        end
        rd(ADR_STAT);
        checks++;
        if (obs_rdata !== 32'h0000_0001) begin
            errors++;
            $display("FAIL unmapped_stat: got %h expected 00000001", obs_rdata);
        end
        rd(ADR_DATA);
        checks++;
        if (obs_rdata !== 32'h0000_013C) begin
            errors++;
            $display("FAIL unmapped_data: got %h expected 0000013c", obs_rdata);
        end
    endtask

    task automatic test_random();
        logic        r, we, rdv, wr;
        logic [7:0]  ch;
        logic [13:0] ra, wa;
        logic [31:0] wd, rin;
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            we  = ($urandom_range(0, 9) < 6);
            ch  = 8'($urandom);
            rdv = ($urandom_range(0, 9) < 5);
            case ($urandom_range(0, 4))
                0:       ra = ADR_DATA;
                1:       ra = ADR_STAT;
                2:       ra = ADR_CTRL;
                default: ra = 14'h0100 + 14'($urandom_range(0, 255));
            endcase
            wr  = ($urandom_range(0, 9) == 0);
            wa  = ($urandom_range(0, 3) == 0) ? 14'h0200 : ADR_CTRL;
            wd  = $urandom;
            if ($urandom_range(0, 3) != 0) wd[2] = 1'b0;
            rin = $urandom;
            cyc(r, we, ch, rdv, ra, wr, wa, wd, rin);
            checks++;
            if (obs_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL random_rdata[%0d]: got %h expected %h", n, obs_rdata, exp_rdata);
            end
            checks++;
            if (obs_irq !== exp_irq) begin
                errors++;
                $display("FAIL random_irq[%0d]: got %b expected %b", n, obs_irq, exp_irq);
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        uart_rx_char    = '0;
        uart_rx_we      = 1'b0;
        dma_io_we       = 1'b0;
        dma_io_wadr     = '0;
        dma_io_wdata    = '0;
        dma_io_radr     = '0;
        dma_io_radr_en  = 1'b0;
        dma_io_rdata_in = '0;
        m_ovr           = 1'b0;
        m_irq_en        = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_overrun();
        test_irq();
        test_full_pushpop();
        test_empty_pushpop();
        test_flush();
        test_unmapped();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_uart_in.md
IO_UART_IN -- requirements
Module: io_uart_in

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 4, giving a receive FIFO of 2**DEPTH_LOG2 bytes.
REQ-002 The block SHALL have parameter ADR_DATA, default 14'h0080, the word address of the RX data register.
REQ-003 The block SHALL have parameter ADR_STAT, default 14'h0081, the word address of the status register.
REQ-004 The block SHALL have parameter ADR_CTRL, default 14'h0082, the word address of the control register.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port uart_rx_char, input, 8 bits: received byte from the UART receiver.
REQ-008 The block SHALL have port uart_rx_we, input, 1 bit: one-cycle strobe; uart_rx_char is valid.
REQ-009 The block SHALL have port dma_io_we, input, 1 bit: IO bus write strobe.
REQ-010 The block SHALL have port dma_io_wadr, input, 14 bits [15:2]: IO write word address.
REQ-011 The block SHALL have port dma_io_wdata, input, 32 bits: IO write data.
REQ-012 The block SHALL have port dma_io_radr, input, 14 bits [15:2]: IO read word address.
REQ-013 The block SHALL have port dma_io_radr_en, input, 1 bit: IO read request strobe.
REQ-014 The block SHALL have port dma_io_rdata_in, input, 32 bits: read data from the previous IO block in the chain.
REQ-015 The block SHALL have port dma_io_rdata, output, 32 bits: read data to the next IO block or the CPU.
REQ-016 The block SHALL have port uart_rx_irq, output, 1 bit: level interrupt, data available.

Function
REQ-017 The block SHALL push uart_rx_char into the FIFO on every cycle with uart_rx_we=1 and FIFO not full, after any same-cycle pop.
REQ-018 The block SHALL drop a byte arriving with FIFO full and no same-cycle pop, and set the sticky overrun flag.
REQ-019 When dma_io_radr_en=1 and dma_io_radr=ADR_DATA in cycle N with FIFO non-empty, the block SHALL pop the head byte in cycle N and drive dma_io_rdata={23'd0,1'b1,byte} in cycle N+1.
REQ-020 A DATA read with FIFO empty SHALL return 32'd0 in cycle N+1 and SHALL NOT change the pointers.
REQ-021 A STAT read SHALL return, in cycle N+1: [DEPTH_LOG2:0]=count, [8]=empty, [9]=full, [10]=overrun, [16]=irq_en, other bits 0, sampled at cycle N.
REQ-022 A CTRL read SHALL return, in cycle N+1: {31'd0,irq_en}.
REQ-023 In any cycle where the previous cycle held no read hitting ADR_DATA, ADR_STAT or ADR_CTRL, dma_io_rdata SHALL equal dma_io_rdata_in combinationally.
REQ-024 A write with dma_io_we=1 and dma_io_wadr=ADR_CTRL SHALL update state as follows: wdata[0] sets irq_en; wdata[1]=1 clears overrun; wdata[2]=1 flushes the FIFO (pointers and count to 0).
REQ-025 Flush and push in the same cycle: flush SHALL win; the byte is discarded and overrun is not set.
REQ-026 Push and pop on an empty FIFO in the same cycle: the read SHALL return 32'd0 and the pushed byte SHALL be stored (count=1).
REQ-027 Push and pop on a full FIFO in the same cycle: both SHALL succeed, count SHALL stay at full, and overrun SHALL NOT be set.
REQ-028 The read and write pointers SHALL be DEPTH_LOG2 bits wide and wrap modulo depth; count SHALL be DEPTH_LOG2+1 bits wide, range 0..depth.
REQ-029 uart_rx_irq SHALL equal irq_en AND (count != 0), derived from registered state.
REQ-030 Writes to other addresses SHALL be ignored, and reads of other addresses SHALL have no side effect.

Reset
REQ-031 On clk edge with rst=1: pointers=0, count=0, overrun=0, irq_en=0, read-select/data registers=0.
REQ-032 While rst=1, the block SHALL ignore uart_rx_we and all bus accesses; uart_rx_irq=0, and dma_io_rdata SHALL equal dma_io_rdata_in.
REQ-033 Reset asserted mid-operation SHALL discard all buffered bytes; the first read after reset SHALL see empty.

Verification
REQ-034 The bench SHALL cover push of 0x41, 0x42, then two DATA reads -> 0x00000141 then 0x00000142, followed by a third read -> 0x00000000.
REQ-035 The bench SHALL cover push of 17 bytes with default depth -> STAT=0x00000610 (count 16, full, overrun); the first 16 bytes are read back in order and the 17th is lost.
REQ-036 The bench SHALL cover a CTRL write of 0x1 followed by a push of 0x55 -> uart_rx_irq=1 the cycle after the push, and 0 the cycle after the DATA pop.
REQ-037 The bench SHALL cover a full FIFO with a simultaneous push and DATA read -> old head returned, count stays 16, overrun stays 0.
REQ-038 The bench SHALL cover a CTRL write of 0x6 with a same-cycle push -> STAT=0x00000100 (empty, overrun cleared).
REQ-039 The bench SHALL cover a read of an unmapped address with dma_io_rdata_in=0xDEADBEEF -> dma_io_rdata=0xDEADBEEF and FIFO unchanged.
